// File: rtl/ball_centroid_pkg.sv
// Shared types and default widths for the ball centroid tracker.
// Holds the control FSM encoding and the hue window test used on the pixel stream.
package ball_centroid_pkg;

    localparam int X_W_DEF   = 10;
    localparam int Y_W_DEF   = 9;
    localparam int CNT_W_DEF = 19;
    localparam int SUM_W_DEF = 29;
    localparam int HUE_W     = 9;
    localparam int SV_W      = 5;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DIV_X,
        DIV_Y,
        DONE
    } state_t;

    // A window with lo > hi wraps through 0 (red hues).
    function automatic logic hue_in_window(input logic [HUE_W-1:0] h,
                                           input logic [HUE_W-1:0] lo,
                                           input logic [HUE_W-1:0] hi);
        if (lo <= hi) return (h >= lo) && (h <= hi);
        return (h >= lo) || (h <= hi);
    endfunction

endpackage

// File: rtl/ball_centroid_if.sv
// Per-pixel HSV stream from rgb2hsv together with the synchronised line/frame syncs.
interface ball_centroid_if;
    import ball_centroid_pkg::*;

    logic             href;
    logic             vsync;
    logic             hsv_valid;
    logic [HUE_W-1:0] hue;
    logic [SV_W-1:0]  saturation;
    logic [SV_W-1:0]  value;
    logic             hue_invalid;

    modport master (output href, vsync, hsv_valid, hue, saturation, value, hue_invalid);
    modport slave  (input  href, vsync, hsv_valid, hue, saturation, value, hue_invalid);

endinterface

// File: rtl/ball_centroid_serial_divider.sv
// Unsigned restoring divider, one quotient bit per clock; done pulses SUM_W+1 cycles after start.
module serial_divider #(
    parameter int SUM_W = 29,
    parameter int CNT_W = 19
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [SUM_W-1:0] quotient
);
    localparam int CW = $clog2(SUM_W + 1);

    logic [CNT_W-1:0] rem;
    logic [CNT_W-1:0] dsr;
    logic [CW-1:0]    cnt;
    logic [CNT_W:0]   trial;
    logic [CNT_W-1:0] diff;
    logic             ge;

    // The dividend shifts out of the quotient register as quotient bits shift in.
    always_comb begin
        trial = {rem, quotient[SUM_W-1]};
        ge    = trial >= {1'b0, dsr};
        diff  = trial[CNT_W-1:0] - dsr;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            rem      <= '0;
            dsr      <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            quotient <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem      <= '0;
                dsr      <= divisor;
                quotient <= dividend;
                cnt      <= CW'(SUM_W);
                busy     <= 1'b1;
            end else if (busy) begin
                rem      <= ge ? diff : trial[CNT_W-1:0];
                quotient <= {quotient[SUM_W-2:0], ge};
                cnt      <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ball_centroid.sv
// Colour-thresholded pixel accumulator; at each frame end divides the x/y sums by the
// matched count to give the ball centroid and pulses result_valid.
module ball_centroid
    import ball_centroid_pkg::*;
#(
    parameter int X_W        = X_W_DEF,
    parameter int Y_W        = Y_W_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int SUM_W      = SUM_W_DEF,
    parameter int MIN_PIXELS = 16
) (
    input  logic             clk,
    input  logic             res,
    ball_centroid_if.slave   pix,
    input  logic [HUE_W-1:0] hue_min,
    input  logic [HUE_W-1:0] hue_max,
    input  logic [SV_W-1:0]  sat_min,
    input  logic [SV_W-1:0]  val_min,
    output logic [X_W-1:0]   centroid_x,
    output logic [Y_W-1:0]   centroid_y,
    output logic [CNT_W-1:0] pixel_count,
    output logic             found,
    output logic             result_valid,
    output logic             overrun
);
    logic             href_q, vsync_q, first_line;
    logic             href_rise, vsync_rise, match;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [CNT_W-1:0] count, snap_count;
    logic [SUM_W-1:0] sum_x, sum_y, snap_sx, snap_sy;

    state_t           state, state_nx;
    logic             div_start, div_sel_y, latch_x, load_res, res_found;
    logic             div_busy, div_done;
    logic [SUM_W-1:0] div_q;
    logic [X_W-1:0]   q_x, quot_x;
    logic [Y_W-1:0]   q_y;
    logic             enough;

    assign href_rise  = pix.href & ~href_q;
    assign vsync_rise = pix.vsync & ~vsync_q;
    assign match      = pix.hsv_valid & ~pix.hue_invalid
                      & (pix.saturation >= sat_min) & (pix.value >= val_min)
                      & hue_in_window(pix.hue, hue_min, hue_max);
    assign enough     = snap_count >= CNT_W'(MIN_PIXELS);

    // Column keeps counting after href falls so late pixels stay on the current line.
    always_ff @(posedge clk) begin
        if (res) begin
            href_q     <= 1'b0;
            vsync_q    <= 1'b1;
            first_line <= 1'b1;
            x          <= '0;
            y          <= '0;
        end else begin
            href_q  <= pix.href;
            vsync_q <= pix.vsync;
            if (href_rise)
                x <= '0;
            else if (pix.hsv_valid && x != '1)
                x <= x + 1'b1;
            if (vsync_rise) begin
                y          <= '0;
                first_line <= 1'b1;
            end else if (href_rise) begin
                first_line <= 1'b0;
                if (!first_line && y != '1)
                    y <= y + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            count      <= '0;
            sum_x      <= '0;
            sum_y      <= '0;
            snap_count <= '0;
            snap_sx    <= '0;
            snap_sy    <= '0;
            overrun    <= 1'b0;
        end else begin
            overrun <= vsync_rise && (state != IDLE);
            if (vsync_rise) begin
                if (state == IDLE) begin
                    snap_count <= count;
                    snap_sx    <= sum_x;
                    snap_sy    <= sum_y;
                end
                // A pixel matching on the frame-end cycle opens the next frame.
                count <= match ? CNT_W'(1) : '0;
                sum_x <= match ? SUM_W'(x) : '0;
                sum_y <= match ? SUM_W'(y) : '0;
            end else if (match && count != '1) begin
                count <= count + 1'b1;
                sum_x <= sum_x + SUM_W'(x);
                sum_y <= sum_y + SUM_W'(y);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (vsync_rise) state_nx = CHECK;
            CHECK:   state_nx = enough ? DIV_X : DONE;
            DIV_X:   if (div_done) state_nx = DIV_Y;
            DIV_Y:   if (div_done) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        div_start = 1'b0;
        div_sel_y = 1'b0;
        latch_x   = 1'b0;
        load_res  = 1'b0;
        res_found = 1'b0;
        case (state)
            CHECK: begin
                div_start = enough & ~div_busy;
                load_res  = ~enough;
            end
            DIV_X: if (div_done) begin
                latch_x   = 1'b1;
                div_start = ~div_busy;
                div_sel_y = 1'b1;
            end
            DIV_Y: if (div_done) begin
                load_res  = 1'b1;
                res_found = 1'b1;
            end
            default: ;
        endcase
    end

    serial_divider #(.SUM_W(SUM_W), .CNT_W(CNT_W)) u_div (
        .clk      (clk),
        .res      (res),
        .start    (div_start),
        .dividend (div_sel_y ? snap_sy : snap_sx),
        .divisor  (snap_count),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_q)
    );

    // Mean of in-range coordinates always fits; clamp keeps the narrowing explicit.
    assign q_x = (|div_q[SUM_W-1:X_W]) ? '1 : div_q[X_W-1:0];
    assign q_y = (|div_q[SUM_W-1:Y_W]) ? '1 : div_q[Y_W-1:0];

    always_ff @(posedge clk) begin
        if (res) begin
            quot_x       <= '0;
            centroid_x   <= '0;
            centroid_y   <= '0;
            pixel_count  <= '0;
            found        <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= load_res;
            if (latch_x) quot_x <= q_x;
            if (load_res) begin
                pixel_count <= snap_count;
                found       <= res_found;
                centroid_x  <= res_found ? quot_x : '0;
                centroid_y  <= res_found ? q_y : '0;
            end
        end
    end

endmodule

// File: tb/tb_ball_centroid.sv
// Randomised frame-level bench: drives frames through the HSV stream and compares each
// frame result against a pixel-list reference of count, coordinate sums and their means.
module tb_ball_centroid;
    import ball_centroid_pkg::*;

    localparam int MODE_FULL = 0, MODE_BLOB = 1, MODE_RAND = 2, MODE_SUB = 3,
                   MODE_XSAT = 4, MODE_WIN = 5;

    logic       clk = 1'b0;
    logic       res;
    logic [8:0] hue_min, hue_max;
    logic [4:0] sat_min, val_min;
    logic [9:0] centroid_x;
    logic [8:0] centroid_y;
    logic [18:0] pixel_count;
    logic       found, result_valid, overrun;

    ball_centroid_if bus();

    ball_centroid dut (
        .clk          (clk),
        .res          (res),
        .pix          (bus),
        .hue_min      (hue_min),
        .hue_max      (hue_max),
        .sat_min      (sat_min),
        .val_min      (val_min),
        .centroid_x   (centroid_x),
        .centroid_y   (centroid_y),
        .pixel_count  (pixel_count),
        .found        (found),
        .result_valid (result_valid),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    longint m_cnt, m_sx, m_sy;
    int          lat;
    logic [38:0] g_vec;
    bit          g_ovr, g_long;

    function automatic bit ref_match(int h, int s, int v, bit inv);
        int lo = int'(hue_min);
        int hi = int'(hue_max);
        if (inv || s < int'(sat_min) || v < int'(val_min)) return 0;
        if (lo <= hi) return (h >= lo) && (h <= hi);
        return (h >= lo) || (h <= hi);
    endfunction

    // {pixel_count, centroid_x, centroid_y, found}
    function automatic logic [38:0] exp_vec();
        bit f = (m_cnt >= 16);
        return {19'(m_cnt), f ? 10'(m_sx / m_cnt) : 10'd0, f ? 9'(m_sy / m_cnt) : 9'd0, f};
    endfunction

    function automatic int exp_lat();
        return (m_cnt >= 16) ? 62 : 2;
    endfunction

    task automatic drive_pixel(int mode, int col, int line);
        int h = 200, s = 31, v = 31, k;
        bit inv = 0;
        case (mode)
            MODE_FULL: begin
                h = $urandom_range(40, 20); s = $urandom_range(31, 8); v = $urandom_range(31, 8);
            end
            MODE_BLOB: if (col >= 100 && col <= 107 && line >= 50 && line <= 57) h = 30;
            MODE_SUB:  if (line == 1 && col < 10) h = 30;
            MODE_XSAT: if (col >= 1020) h = 30;
            MODE_WIN: case (col % 4)
                0: h = 355;
                1: h = 5;
                2: h = 180;
                default: begin h = 0; inv = 1; end
            endcase
            default: begin
                k = $urandom_range(3, 0);
                h = (k == 2) ? int'(hue_min) : (k == 3) ? int'(hue_max) : int'($urandom_range(359, 0));
                s = $urandom_range(31, 0); v = $urandom_range(31, 0);
                inv = ($urandom_range(7, 0) == 0);
            end
        endcase
        bus.hsv_valid = 1; bus.hue = 9'(h); bus.saturation = 5'(s); bus.value = 5'(v);
        bus.hue_invalid = inv;
        if (ref_match(h, s, v, inv) && m_cnt < 524287) begin
            m_cnt++;
            m_sx += (col > 1023) ? 1023 : col;
            m_sy += (line > 511) ? 511 : line;
        end
        @(negedge clk);
    endtask

    task automatic run_frame(int mode, int w, int h, bit gaps);
        m_cnt = 0; m_sx = 0; m_sy = 0;
        bus.vsync = 0; bus.href = 0; bus.hsv_valid = 0;
        repeat (2) @(negedge clk);
        for (int ln = 0; ln < h; ln++) begin
            bus.href = 1; bus.hsv_valid = 0;
            @(negedge clk);
            for (int c = 0; c < w; c++) begin
                if (gaps && $urandom_range(3, 0) == 0) begin
                    bus.hsv_valid = 0;
                    @(negedge clk);
                end
                drive_pixel(mode, c, ln);
            end
            bus.hsv_valid = 0; bus.href = 0;
            @(negedge clk);
        end
    endtask

    task automatic end_frame();
        bus.vsync = 1; bus.hsv_valid = 0;
        lat = -1; g_ovr = 0; g_vec = '0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (overrun) g_ovr = 1;
            if (result_valid) begin
                lat = k;
                g_vec = {pixel_count, centroid_x, centroid_y, found};
                break;
            end
        end
        @(negedge clk);
        g_long = result_valid;
    endtask

    task automatic test_reset();
        res = 1;
        repeat (3) @(negedge clk);
        checks++;
        if ({pixel_count, centroid_x, centroid_y, found, result_valid, overrun} !== 40'd0) begin
            errors++; $display("FAIL reset_held got %h exp 0", {pixel_count, centroid_x, centroid_y, found});
        end
        res = 0;
        @(negedge clk);
        checks++;
        if ({pixel_count, centroid_x, centroid_y, found, result_valid, overrun} !== 40'd0) begin
            errors++; $display("FAIL reset_release got %h exp 0", {pixel_count, centroid_x, centroid_y, found});
        end
    endtask

    task automatic test_full_frame();
        hue_min = 20; hue_max = 40; sat_min = 8; val_min = 8;
        run_frame(MODE_FULL, 64, 48, 0);
        end_frame();
        checks++;
        if (lat !== 62) begin errors++; $display("FAIL full_latency got %0d exp 62", lat); end
        checks++;
        if (g_vec !== {19'd3072, 10'd31, 9'd23, 1'b1} || g_vec !== exp_vec()) begin
            errors++; $display("FAIL full_result got %h exp %h", g_vec, exp_vec());
        end
        checks++;
        if (g_long !== 1'b0 || g_ovr !== 1'b0) begin
            errors++; $display("FAIL full_pulse got long=%0b ovr=%0b exp 0 0", g_long, g_ovr);
        end
        repeat (5) @(negedge clk);
        checks++;
        if ({pixel_count, centroid_x, centroid_y, found} !== exp_vec()) begin
            errors++; $display("FAIL full_hold got %h exp %h", {pixel_count, centroid_x, centroid_y, found}, exp_vec());
        end
    endtask

    task automatic test_blob();
        hue_min = 20; hue_max = 40; sat_min = 8; val_min = 8;
        run_frame(MODE_BLOB, 112, 60, 1);
        end_frame();
        checks++;
        if (lat !== 62) begin errors++; $display("FAIL blob_latency got %0d exp 62", lat); end
        checks++;
        if (g_vec !== {19'd64, 10'd103, 9'd53, 1'b1} || g_vec !== exp_vec()) begin
            errors++; $display("FAIL blob_result got %h exp %h", g_vec, exp_vec());
        end
    endtask

    task automatic test_wrap();
        hue_min = 350; hue_max = 10; sat_min = 4; val_min = 4;
        run_frame(MODE_WIN, 16, 4, 1);
        end_frame();
        checks++;
        if (lat !== exp_lat() || g_vec !== exp_vec() || g_vec[38:20] !== 19'd32) begin
            errors++; $display("FAIL wrap_fixed got lat=%0d %h exp lat=%0d %h", lat, g_vec, exp_lat(), exp_vec());
        end
        run_frame(MODE_RAND, 24, 6, 1);
        end_frame();
        checks++;
        if (lat !== exp_lat() || g_vec !== exp_vec()) begin
            errors++; $display("FAIL wrap_rand got lat=%0d %h exp lat=%0d %h", lat, g_vec, exp_lat(), exp_vec());
        end
    endtask

    task automatic test_sub_threshold();
        hue_min = 20; hue_max = 40; sat_min = 8; val_min = 8;
        run_frame(MODE_SUB, 16, 3, 0);
        end_frame();
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL sub_latency got %0d exp 2", lat); end
        checks++;
        if (g_vec !== {19'd10, 10'd0, 9'd0, 1'b0} || g_vec !== exp_vec()) begin
            errors++; $display("FAIL sub_result got %h exp %h", g_vec, exp_vec());
        end
    endtask

    task automatic test_xsat();
        hue_min = 20; hue_max = 40; sat_min = 8; val_min = 8;
        run_frame(MODE_XSAT, 1100, 1, 0);
        end_frame();
        checks++;
        if (lat !== 62 || g_vec !== exp_vec() || g_vec[38:20] !== 19'd80) begin
            errors++; $display("FAIL xsat_result got lat=%0d %h exp lat=62 %h", lat, g_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            hue_min = 9'($urandom_range(359, 0)); hue_max = 9'($urandom_range(359, 0));
            sat_min = 5'($urandom_range(20, 0));  val_min = 5'($urandom_range(20, 0));
            run_frame(MODE_RAND, $urandom_range(40, 8), $urandom_range(12, 4), 1);
            end_frame();
            checks++;
            if (lat !== exp_lat() || g_vec !== exp_vec() || g_ovr !== 1'b0) begin
                errors++; $display("FAIL random_%0d got lat=%0d %h exp lat=%0d %h", n, lat, g_vec, exp_lat(), exp_vec());
            end
        end
    endtask

    task automatic test_overrun();
        logic [38:0] e_vec, rv_vec;
        int ovr_k = -1, ovr_n = 0, rv_k = -1;
        hue_min = 20; hue_max = 40; sat_min = 8; val_min = 8;
        run_frame(MODE_FULL, 16, 4, 0);
        e_vec = exp_vec(); rv_vec = '0;
        bus.vsync = 1; bus.hsv_valid = 0;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            if (overrun) begin ovr_n++; if (ovr_k < 0) ovr_k = k; end
            if (result_valid && rv_k < 0) begin
                rv_k = k; rv_vec = {pixel_count, centroid_x, centroid_y, found};
            end
            // Matching pixels inside the dropped frame must not leak into the next one.
            bus.hsv_valid = (k >= 2 && k <= 15);
            bus.hue = 9'd30; bus.saturation = 5'd31; bus.value = 5'd31; bus.hue_invalid = 0;
            if (k == 18) bus.vsync = 0;
            if (k == 20) bus.vsync = 1;
        end
        bus.hsv_valid = 0;
        checks++;
        if (ovr_k !== 21 || ovr_n !== 1) begin
            errors++; $display("FAIL overrun_pulse got at=%0d n=%0d exp at=21 n=1", ovr_k, ovr_n);
        end
        checks++;
        if (rv_k !== 62 || rv_vec !== e_vec) begin
            errors++; $display("FAIL overrun_first got lat=%0d %h exp lat=62 %h", rv_k, rv_vec, e_vec);
        end
        run_frame(MODE_FULL, 8, 4, 0);
        end_frame();
        checks++;
        if (lat !== exp_lat() || g_vec !== exp_vec()) begin
            errors++; $display("FAIL overrun_next got lat=%0d %h exp lat=%0d %h", lat, g_vec, exp_lat(), exp_vec());
        end
    endtask

    task automatic test_reset_mid_div();
        bit rv_seen = 0;
        hue_min = 20; hue_max = 40; sat_min = 8; val_min = 8;
        run_frame(MODE_FULL, 16, 4, 0);
        bus.vsync = 1; bus.hsv_valid = 0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (k >= 41 && result_valid) rv_seen = 1;
            if (k == 40) res = 1;
            if (k == 41) begin
                checks++;
                if ({pixel_count, centroid_x, centroid_y, found, result_valid, overrun} !== 40'd0) begin
                    errors++; $display("FAIL middiv_clear got %h exp 0", {pixel_count, centroid_x, centroid_y, found});
                end
                res = 0;
            end
        end
        checks++;
        if (rv_seen !== 1'b0) begin errors++; $display("FAIL middiv_no_result got 1 exp 0"); end
        run_frame(MODE_FULL, 16, 8, 1);
        end_frame();
        checks++;
        if (lat !== exp_lat() || g_vec !== exp_vec()) begin
            errors++; $display("FAIL middiv_after got lat=%0d %h exp lat=%0d %h", lat, g_vec, exp_lat(), exp_vec());
        end
    endtask

    initial begin
        res = 1;
        bus.href = 0; bus.vsync = 1; bus.hsv_valid = 0; bus.hue = '0;
        bus.saturation = '0; bus.value = '0; bus.hue_invalid = 0;
        hue_min = 20; hue_max = 40; sat_min = 8; val_min = 8;
        test_reset();
        test_full_frame();
        test_blob();
        test_wrap();
        test_sub_threshold();
        test_xsat();
        test_random();
        test_overrun();
        test_reset_mid_div();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
